alu_pipe: RTL and testbench

//  Parametrised, handshaked execute unit: RV32I/RV64I integer ops plus optional iterative RV M-ext mul/div.

---
 rtl/alu_pipe_if.sv | 46 ++++
 rtl/alu_pipe.sv | 267 ++++++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_pipe_if                                                  |
// | Description : Request/result handshake bundle for the alu_pipe execute     |
// |               unit. The master drives ops and accepts results. The slave   |
// |               (alu_pipe) accepts ops and presents results.                 |
// | Ports       : i_valid/o_ready       op request handshake                   |
// |               i_in_a, i_in_b        operands (XLEN)                        |
// |               i_funct3, i_funct7_5  op select                              |
// |               i_alu_en, i_alu_imm   force-ADD / immediate-form controls    |
// |               i_muldiv              M-extension op select                  |
// |               o_valid/i_ready       result handshake                       |
// |               o_alu_out             result (XLEN)                          |
// |               o_busy                iterative mul/div in progress          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface alu_pipe_if #(
   parameter int XLEN = 32
);
   logic            i_valid;
   logic            o_ready;
   logic [XLEN-1:0] i_in_a;
   logic [XLEN-1:0] i_in_b;
   logic [2:0]      i_funct3;
   logic            i_funct7_5;
   logic            i_alu_en;
   logic            i_alu_imm;
   logic            i_muldiv;
   logic            o_valid;
   logic            i_ready;
   logic [XLEN-1:0] o_alu_out;
   logic            o_busy;

   modport master (
      output i_valid, i_in_a, i_in_b, i_funct3, i_funct7_5,
             i_alu_en, i_alu_imm, i_muldiv, i_ready,
      input  o_ready, o_valid, o_alu_out, o_busy
   );

   modport slave (
      input  i_valid, i_in_a, i_in_b, i_funct3, i_funct7_5,
             i_alu_en, i_alu_imm, i_muldiv, i_ready,
      output o_ready, o_valid, o_alu_out, o_busy
   );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_pipe                                                     |
// | Description : Handshaked RV32I/RV64I integer execute unit with optional    |
// |               iterative M-extension multiply/divide. One op is in flight.  |
// |               The result is registered and held until downstream takes it. |
// | Parameters  : XLEN     datapath width (32 or 64)                           |
// |               MUL_STEP multiplier bits retired per cycle (1, 2 or 4)       |
// | Macro       : ALU_MULDIV_EN  builds the mul/div datapath and FSM. Without  |
// |               it, M-ops complete in one cycle with a zero result.          |
// | Ports       : i_clk   clock, rising edge                                   |
// |               i_rst_n synchronous active-low reset                         |
// |               bus     alu_pipe_if slave (op request, result, o_busy)       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alu_pipe #(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 1
) (
   input  wire logic  i_clk,
   input  wire logic  i_rst_n,
   alu_pipe_if.slave  bus
);

   localparam int c_shw = $clog2(XLEN);

   generate
      if ((XLEN != 32 && XLEN != 64) ||
          (MUL_STEP != 1 && MUL_STEP != 2 && MUL_STEP != 4) ||
          ((XLEN % MUL_STEP) != 0)) begin : g_bad_param
         $error("alu_pipe: unsupported XLEN/MUL_STEP combination");
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Single-cycle base ALU
   // ---------------------------------------------------------------------
   logic [c_shw-1:0] w_shamt;
   logic             w_do_sub;
   logic [XLEN-1:0]  w_addsub;
   logic [XLEN-1:0]  w_base_res;

   assign w_shamt  = bus.i_in_b[c_shw-1:0];
   // Immediate forms have no SUB; funct7_5 there only means SRAI.
   assign w_do_sub = bus.i_alu_en && !bus.i_alu_imm && bus.i_funct7_5;
   assign w_addsub = w_do_sub ? (bus.i_in_a - bus.i_in_b) : (bus.i_in_a + bus.i_in_b);

   always_comb begin
      w_base_res = w_addsub;
      if (bus.i_alu_en) begin
         case (bus.i_funct3)
            3'b000: w_base_res = w_addsub;
            3'b001: w_base_res = bus.i_in_a << w_shamt;
            3'b010: w_base_res = {{(XLEN-1){1'b0}}, ($signed(bus.i_in_a) < $signed(bus.i_in_b))};
            3'b011: w_base_res = {{(XLEN-1){1'b0}}, (bus.i_in_a < bus.i_in_b)};
            3'b100: w_base_res = bus.i_in_a ^ bus.i_in_b;
            3'b101: w_base_res = bus.i_funct7_5 ? XLEN'($signed(bus.i_in_a) >>> w_shamt)
                                                : (bus.i_in_a >> w_shamt);
            3'b110: w_base_res = bus.i_in_a | bus.i_in_b;
            3'b111: w_base_res = bus.i_in_a & bus.i_in_b;
            default: w_base_res = w_addsub;
         endcase
      end
   end

   logic            r_valid;
   logic [XLEN-1:0] r_out;
   logic            w_ready;
   logic            w_accept;
   logic            w_consume;

   assign w_accept      = bus.i_valid && w_ready;
   assign w_consume     = r_valid && bus.i_ready;
   assign bus.o_ready   = w_ready;
   assign bus.o_valid   = r_valid;
   assign bus.o_alu_out = r_out;

`ifdef ALU_MULDIV_EN
   // ---------------------------------------------------------------------
   // Iterative M-extension datapath
   // ---------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int                 c_cnt_w    = $clog2(XLEN);
   localparam logic [c_cnt_w-1:0] c_mul_last = c_cnt_w'(XLEN / MUL_STEP - 1);
   localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(XLEN - 1);
   localparam logic [XLEN-1:0]    c_min_neg  = {1'b1, {(XLEN-1){1'b0}}};

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [2*XLEN-1:0]   r_mcand;
   logic [2*XLEN-1:0]   r_acc;
   logic [XLEN-1:0]     r_mplier;
   logic [XLEN-1:0]     r_divisor;
   logic [XLEN-1:0]     r_quo;
   logic [XLEN-1:0]     r_rem;
   logic                r_neg;      // product / quotient sign
   logic                r_rneg;     // remainder sign (follows dividend)
   logic                r_is_div;
   logic [1:0]          r_sel;      // funct3[1:0] of the op in flight

   // Operand conditioning at accept: signedness, magnitudes, special cases.
   logic            w_is_div;
   logic            w_a_sgn;
   logic            w_b_sgn;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_mag_a;
   logic [XLEN-1:0] w_mag_b;
   logic            w_div_zero;
   logic            w_div_ovf;
   logic            w_fast;
   logic [XLEN-1:0] w_fast_res;

   assign w_is_div   = bus.i_funct3[2];
   // MULH: both signed, MULHSU: A signed, DIV/REM: both signed.
   assign w_a_sgn    = w_is_div ? !bus.i_funct3[0]
                                : (bus.i_funct3[1:0] == 2'b01 || bus.i_funct3[1:0] == 2'b10);
   assign w_b_sgn    = w_is_div ? !bus.i_funct3[0] : (bus.i_funct3[1:0] == 2'b01);
   assign w_a_neg    = w_a_sgn && bus.i_in_a[XLEN-1];
   assign w_b_neg    = w_b_sgn && bus.i_in_b[XLEN-1];
   assign w_mag_a    = w_a_neg ? -bus.i_in_a : bus.i_in_a;
   assign w_mag_b    = w_b_neg ? -bus.i_in_b : bus.i_in_b;
   assign w_div_zero = w_is_div && (bus.i_in_b == '0);
   assign w_div_ovf  = w_is_div && !bus.i_funct3[0] &&
                       (bus.i_in_a == c_min_neg) && (bus.i_in_b == '1);
   assign w_fast     = !bus.i_muldiv || w_div_zero || w_div_ovf;

   always_comb begin
      w_fast_res = w_base_res;
      if (bus.i_muldiv) begin
         if (w_div_zero)     w_fast_res = bus.i_funct3[1] ? bus.i_in_a : '1;
         else if (w_div_ovf) w_fast_res = bus.i_funct3[1] ? '0 : c_min_neg;
         else                w_fast_res = '0;
      end
   end

   // Shift-add step: add MUL_STEP shifted copies of the multiplicand.
   logic [2*XLEN-1:0] w_acc_nxt;
   always_comb begin
      w_acc_nxt = r_acc;
      for (int j = 0; j < MUL_STEP; j++) begin
         if (r_mplier[j]) w_acc_nxt = w_acc_nxt + (r_mcand << j);
      end
   end

   // Restoring division step. The partial remainder is always below the
   // divisor, so XLEN bits hold it; the shifted value needs one more bit.
   logic [XLEN:0]   w_div_shift;
   logic            w_div_fits;
   logic [XLEN-1:0] w_div_rem_nxt;

   assign w_div_shift   = {r_rem, r_quo[XLEN-1]};
   assign w_div_fits    = (w_div_shift >= {1'b0, r_divisor});
   assign w_div_rem_nxt = w_div_fits ? (w_div_shift[XLEN-1:0] - r_divisor)
                                     : w_div_shift[XLEN-1:0];

   // Sign fix-up and half select in DONE.
   logic [2*XLEN-1:0] w_prod_fix;
   logic [XLEN-1:0]   w_quo_fix;
   logic [XLEN-1:0]   w_rem_fix;
   logic [XLEN-1:0]   w_done_res;

   assign w_prod_fix = r_neg  ? -r_acc : r_acc;
   assign w_quo_fix  = r_neg  ? -r_quo : r_quo;
   assign w_rem_fix  = r_rneg ? -r_rem : r_rem;

   always_comb begin
      w_done_res = w_prod_fix[XLEN-1:0];
      if (r_is_div)             w_done_res = r_sel[1] ? w_rem_fix : w_quo_fix;
      else if (r_sel != 2'b00)  w_done_res = w_prod_fix[2*XLEN-1:XLEN];
   end

   assign w_ready    = (r_state == S_IDLE) && (!r_valid || bus.i_ready);
   assign bus.o_busy = (r_state == S_MUL) || (r_state == S_DIV);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept && !w_fast) w_state_nxt = w_is_div ? S_DIV : S_MUL;
         S_MUL:  if (r_cnt == c_mul_last) w_state_nxt = S_DONE;
         S_DIV:  if (r_cnt == c_div_last) w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_out   <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_consume) r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt <= '0;
                  if (w_fast) begin
                     r_valid <= 1'b1;
                     r_out   <= w_fast_res;
                  end else begin
                     r_neg    <= w_a_neg ^ w_b_neg;
                     r_rneg   <= w_a_neg;
                     r_is_div <= w_is_div;
                     r_sel    <= bus.i_funct3[1:0];
                     r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
                     r_mplier <= w_mag_b;
                     r_acc    <= '0;
                     r_quo    <= w_mag_a;
                     r_rem    <= '0;
                     r_divisor <= w_mag_b;
                  end
               end
            end
            S_MUL: begin
               r_acc    <= w_acc_nxt;
               r_mcand  <= r_mcand << MUL_STEP;
               r_mplier <= r_mplier >> MUL_STEP;
               r_cnt    <= r_cnt + 1'b1;
            end
            S_DIV: begin
               r_rem <= w_div_rem_nxt;
               r_quo <= {r_quo[XLEN-2:0], w_div_fits};
               r_cnt <= r_cnt + 1'b1;
            end
            S_DONE: begin
               r_valid <= 1'b1;
               r_out   <= w_done_res;
            end
            default: ;
         endcase
      end
   end
`else
   // No M-extension: every accepted op completes in one cycle and M-ops
   // return zero.
   assign w_ready    = !r_valid || bus.i_ready;
   assign bus.o_busy = 1'b0;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_out   <= '0;
      end else begin
         if (w_consume) r_valid <= 1'b0;
         if (w_accept) begin
            r_valid <= 1'b1;
            r_out   <= bus.i_muldiv ? '0 : w_base_res;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_pipe                                                  |
// | Description : Directed self-checking bench for alu_pipe (XLEN=32,          |
// |               MUL_STEP=1). M-ext expectations follow ALU_MULDIV_EN.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_alu_pipe;
   localparam int XLEN = 32;

`ifdef ALU_MULDIV_EN
   localparam bit c_md = 1'b1;
`else
   localparam bit c_md = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   alu_pipe_if #(.XLEN(XLEN)) bus ();

   alu_pipe #(.XLEN(XLEN), .MUL_STEP(1)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f3;
      logic        f75;
      logic        en;
      logic        imm;
      logic [31:0] exp;
   } base_vec_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f3;
      logic [31:0] exp;
      int          lat;
      int          busy;
   } md_vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                           input logic f75, input logic en, input logic imm, input logic md);
      bus.i_valid    = 1'b1;
      bus.i_in_a     = a;
      bus.i_in_b     = b;
      bus.i_funct3   = f3;
      bus.i_funct7_5 = f75;
      bus.i_alu_en   = en;
      bus.i_alu_imm  = imm;
      bus.i_muldiv   = md;
   endtask

   task automatic test_reset();
      bus.i_ready = 1'b1;
      drive_op(32'd0, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      bus.i_valid = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      n_tests++;
      if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
      n_tests++;
      if (bus.o_alu_out !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h want 00000000", bus.o_alu_out); end
      n_tests++;
      if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
      n_tests++;
      if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_base_ops();
      base_vec_t v [15];
      v[0]  = '{32'd5,        32'd7,        3'b000, 1'b0, 1'b1, 1'b0, 32'h0000000C}; // ADD
      v[1]  = '{32'd5,        32'd7,        3'b000, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE}; // SUB
      v[2]  = '{32'h80000000, 32'd4,        3'b101, 1'b1, 1'b1, 1'b0, 32'hF8000000}; // SRA
      v[3]  = '{32'h80000000, 32'd4,        3'b101, 1'b0, 1'b1, 1'b0, 32'h08000000}; // SRL
      v[4]  = '{32'h80000000, 32'd0,        3'b001, 1'b0, 1'b1, 1'b0, 32'h80000000}; // SLL 0
      v[5]  = '{32'hFFFFFFFF, 32'd1,        3'b010, 1'b0, 1'b1, 1'b0, 32'h00000001}; // SLT
      v[6]  = '{32'hFFFFFFFF, 32'd1,        3'b011, 1'b0, 1'b1, 1'b0, 32'h00000000}; // SLTU
      v[7]  = '{32'd5,        32'd7,        3'b000, 1'b1, 1'b1, 1'b1, 32'h0000000C}; // ADDI, no SUB
      v[8]  = '{32'd5,        32'd7,        3'b100, 1'b0, 1'b0, 1'b0, 32'h0000000C}; // alu_en=0 -> ADD
      v[9]  = '{32'h0000F0F0, 32'h0000FF00, 3'b100, 1'b0, 1'b1, 1'b0, 32'h00000FF0}; // XOR
      v[10] = '{32'h0000F0F0, 32'h0000FF00, 3'b110, 1'b0, 1'b1, 1'b0, 32'h0000FFF0}; // OR
      v[11] = '{32'h0000F0F0, 32'h0000FF00, 3'b111, 1'b0, 1'b1, 1'b0, 32'h0000F000}; // AND
      v[12] = '{32'h80000000, 32'h00000024, 3'b101, 1'b1, 1'b1, 1'b0, 32'hF8000000}; // shamt low bits only
      v[13] = '{32'hFFFFFFFF, 32'd1,        3'b000, 1'b0, 1'b1, 1'b0, 32'h00000000}; // ADD wraps
      v[14] = '{32'h80000000, 32'd1,        3'b101, 1'b1, 1'b1, 1'b1, 32'hC0000000}; // SRAI
      bus.i_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         drive_op(v[i].a, v[i].b, v[i].f3, v[i].f75, v[i].en, v[i].imm, 1'b0);
         #1;
         n_tests++;
         if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL base_ready[%0d]: got %b want 1", i, bus.o_ready); end
         tick();
         n_tests++;
         if (bus.o_valid !== 1'b1 || bus.o_alu_out !== v[i].exp) begin
            n_fail++;
            $display("FAIL base_op[%0d]: got valid=%b out=%h want valid=1 out=%h", i, bus.o_valid, bus.o_alu_out, v[i].exp);
         end
      end
      bus.i_valid = 1'b0;
      tick();
      n_tests++;
      if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL base_drain: got valid=%b want 0", bus.o_valid); end
   endtask

   task automatic test_muldiv();
      md_vec_t     v [14];
      int          lat;
      int          busy_cnt;
      int          rdy_bad;
      logic [31:0] exp;
      int          exp_lat;
      int          exp_busy;
      v[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32'hFFFFFFFE, 33, 32}; // MULHU
      v[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 32'h00000001, 33, 32}; // MUL
      v[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 32'h00000000, 33, 32}; // MULH -1*-1
      v[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010, 32'hFFFFFFFF, 33, 32}; // MULHSU
      v[4]  = '{32'h80000000, 32'h80000000, 3'b001, 32'h40000000, 33, 32}; // MULH
      v[5]  = '{32'hFFFFFFFE, 32'd3,        3'b001, 32'hFFFFFFFF, 33, 32}; // MULH -2*3
      v[6]  = '{32'h80000000, 32'hFFFFFFFF, 3'b100, 32'h80000000, 0,  0};  // DIV overflow
      v[7]  = '{32'h80000000, 32'hFFFFFFFF, 3'b110, 32'h00000000, 0,  0};  // REM overflow
      v[8]  = '{32'd7,        32'd0,        3'b101, 32'hFFFFFFFF, 0,  0};  // DIVU /0
      v[9]  = '{32'd7,        32'd0,        3'b111, 32'h00000007, 0,  0};  // REMU /0
      v[10] = '{32'hFFFFFFF9, 32'd2,        3'b100, 32'hFFFFFFFD, 33, 32}; // DIV -7/2
      v[11] = '{32'hFFFFFFF9, 32'd2,        3'b110, 32'hFFFFFFFF, 33, 32}; // REM -7/2
      v[12] = '{32'd100,      32'd7,        3'b111, 32'h00000002, 33, 32}; // REMU
      v[13] = '{32'd7,        32'hFFFFFFFE, 3'b100, 32'hFFFFFFFD, 33, 32}; // DIV 7/-2
      bus.i_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         exp      = c_md ? v[i].exp  : 32'h0;
         exp_lat  = c_md ? v[i].lat  : 0;
         exp_busy = c_md ? v[i].busy : 0;
         drive_op(v[i].a, v[i].b, v[i].f3, 1'b0, 1'b1, 1'b0, 1'b1);
         tick();
         bus.i_valid = 1'b0;
         lat = 0;
         busy_cnt = 0;
         rdy_bad = 0;
         while (bus.o_valid !== 1'b1 && lat < 100) begin
            if (bus.o_busy === 1'b1) busy_cnt++;
            if (bus.o_ready !== 1'b0) rdy_bad++;
            tick();
            lat++;
         end
         n_tests++;
         if (bus.o_valid !== 1'b1 || bus.o_alu_out !== exp) begin
            n_fail++;
            $display("FAIL md_result[%0d]: got valid=%b out=%h want valid=1 out=%h", i, bus.o_valid, bus.o_alu_out, exp);
         end
         n_tests++;
         if (lat != exp_lat) begin n_fail++; $display("FAIL md_latency[%0d]: got %0d want %0d", i, lat, exp_lat); end
         n_tests++;
         if (busy_cnt != exp_busy) begin n_fail++; $display("FAIL md_busy[%0d]: got %0d want %0d", i, busy_cnt, exp_busy); end
         n_tests++;
         if (rdy_bad != 0) begin n_fail++; $display("FAIL md_ready_low[%0d]: got %0d ready cycles want 0", i, rdy_bad); end
         tick();
      end
   endtask

   task automatic test_backpressure();
      bus.i_ready = 1'b0;
      drive_op(32'd1, 32'd2, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      // A different op offered during the stall must be ignored.
      drive_op(32'h100, 32'h200, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         n_tests++;
         if (bus.o_valid !== 1'b1 || bus.o_alu_out !== 32'd3) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got valid=%b out=%h want valid=1 out=00000003", k, bus.o_valid, bus.o_alu_out);
         end
         n_tests++;
         if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", k, bus.o_ready); end
         tick();
      end
      bus.i_ready = 1'b1;
      drive_op(32'd10, 32'd20, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      n_tests++;
      if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus.o_ready); end
      tick();
      bus.i_valid = 1'b0;
      n_tests++;
      if (bus.o_valid !== 1'b1 || bus.o_alu_out !== 32'd30) begin
         n_fail++;
         $display("FAIL bp_next: got valid=%b out=%h want valid=1 out=0000001e", bus.o_valid, bus.o_alu_out);
      end
      tick();
      n_tests++;
      if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got valid=%b want 0", bus.o_valid); end
   endtask

   task automatic test_reset_mid_div();
      int stale;
      bus.i_ready = 1'b0;
      drive_op(32'd100, 32'd7, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      bus.i_valid = 1'b0;
      repeat (9) tick();
      n_tests++;
      if (bus.o_busy !== c_md) begin n_fail++; $display("FAIL rst_mid_busy: got %b want %b", bus.o_busy, c_md); end
      rst_n = 1'b0;
      tick();
      n_tests++;
      if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_alu_out !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid_state: got valid=%b busy=%b ready=%b out=%h want 0 0 1 00000000",
                  bus.o_valid, bus.o_busy, bus.o_ready, bus.o_alu_out);
      end
      rst_n = 1'b1;
      stale = 0;
      repeat (40) begin
         tick();
         if (bus.o_valid !== 1'b0) stale++;
      end
      n_tests++;
      if (stale != 0) begin n_fail++; $display("FAIL rst_mid_stale: got %0d valid cycles want 0", stale); end
      bus.i_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_base_ops();
      test_muldiv();
      test_backpressure();
      test_reset_mid_div();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
